// File: rtl/gray_rx_monitor_if.sv
// Sample/result bundle between a Gray-code count source and its monitor.
// Carries the qualified 4-bit Gray sample in and the decoded result and status pulses out.
// No backpressure: the monitor accepts every sample marked valid.
interface gray_rx_monitor_if #(
  parameter int ERR_W = 8
);
  logic [3:0]       gray_in;
  logic             valid_in;
  logic [3:0]       bin_out;
  logic             bin_valid;
  logic             up_pulse;
  logic             down_pulse;
  logic             wrap_pulse;
  logic             step_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  // Source side: drives samples, observes results.
  modport master (
    output gray_in, valid_in,
    input  bin_out, bin_valid, up_pulse, down_pulse, wrap_pulse,
           step_err, locked, err_count
  );

  // Monitor side: consumes samples, produces results.
  modport slave (
    input  gray_in, valid_in,
    output bin_out, bin_valid, up_pulse, down_pulse, wrap_pulse,
           step_err, locked, err_count
  );
endinterface

// File: rtl/gray_rx_monitor.sv
// Decodes a 4-bit Gray count stream and classifies each accepted step as +1, -1 or illegal.
// Latency 1: every output is registered and reflects the sample taken at the previous edge.
// No backpressure: each valid_in=1 cycle is consumed; valid_in=0 holds state and clears pulses.
module gray_rx_monitor #(
  parameter int ERR_W = 8
) (
  input logic            clk,
  input logic            rst,
  gray_rx_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_LOCK   = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       ref_q, ref_d;
  logic [3:0]       bin_q, bin_d;
  logic             bin_vld_q, bin_vld_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0]       dec;
  logic [3:0]       delta;

  // Gray-to-binary decode of the incoming sample (prefix XOR from the MSB down).
  always_comb begin
    dec    = 4'd0;
    dec[3] = bus.gray_in[3];
    dec[2] = dec[3] ^ bus.gray_in[2];
    dec[1] = dec[2] ^ bus.gray_in[1];
    dec[0] = dec[1] ^ bus.gray_in[0];
  end

  // Next-state and output decision; the reference only matters while locked.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    bin_d     = bin_q;
    bin_vld_d = 1'b0;
    up_d      = 1'b0;
    down_d    = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    delta     = dec - ref_q;

    if (bus.valid_in) begin
      bin_d     = dec;
      bin_vld_d = 1'b1;
      case (state_q)
        ST_LOCK: begin
          if (delta == 4'd1) begin
            up_d   = 1'b1;
            wrap_d = (ref_q == 4'd15);
            ref_d  = dec;
          end else if (delta == 4'd15) begin
            down_d = 1'b1;
            wrap_d = (ref_q == 4'd0);
            ref_d  = dec;
          end else if (delta != 4'd0) begin
            // Untrusted jump: drop the lock and take the next sample as a fresh reference.
            err_d   = 1'b1;
            state_d = ST_RESYNC;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          // INIT and RESYNC both adopt the sample as the new reference without judging it.
          ref_d   = dec;
          state_d = ST_LOCK;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCK);
  end

  // State and output registers with synchronous reset taking priority over any sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      ref_q     <= 4'd0;
      bin_q     <= 4'd0;
      bin_vld_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      bin_q     <= bin_d;
      bin_vld_q <= bin_vld_d;
      up_q      <= up_d;
      down_q    <= down_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.bin_valid  = bin_vld_q;
  assign bus.up_pulse   = up_q;
  assign bus.down_pulse = down_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.step_err   = err_q;
  assign bus.locked     = locked_q;
  assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_gray_rx_monitor.sv
// Directed bench for the Gray-count monitor, one instance at the default counter width and one narrow.
// Results are read #1 after the rising edge that captured the sample.
// Inputs are driven #1 after the edge; the monitor never stalls the source.
module tb_gray_rx_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  gray_rx_monitor_if #(.ERR_W(8)) bus8 ();
  gray_rx_monitor_if #(.ERR_W(2)) bus2 ();

  gray_rx_monitor #(.ERR_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  gray_rx_monitor #(.ERR_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse vector order: {bin_valid, up, down, wrap, step_err}
  task automatic chk8(input string tag, input logic [3:0] bin, input logic [4:0] pul,
                      input logic lck, input logic [7:0] ec);
    chk({tag, ".bin"}, 32'(bus8.bin_out), 32'(bin));
    chk({tag, ".pul"}, 32'({bus8.bin_valid, bus8.up_pulse, bus8.down_pulse,
                            bus8.wrap_pulse, bus8.step_err}), 32'(pul));
    chk({tag, ".lck"}, 32'(bus8.locked), 32'(lck));
    chk({tag, ".ec"}, 32'(bus8.err_count), 32'(ec));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send8(input logic [3:0] g);
    bus8.valid_in = 1'b1;
    bus8.gray_in  = g;
    @(posedge clk); #1;
    bus8.valid_in = 1'b0;
  endtask

  task automatic send2(input logic [3:0] g);
    bus2.valid_in = 1'b1;
    bus2.gray_in  = g;
    @(posedge clk); #1;
    bus2.valid_in = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    bus8.valid_in = 1'b0;
    bus8.gray_in  = 4'd0;
    bus2.valid_in = 1'b0;
    bus2.gray_in  = 4'd0;

    // Reset state
    do_reset();
    chk8("rst", 4'd0, 5'b00000, 1'b0, 8'd0);

    // Counting up 0..3
    send8(4'b0000); chk8("up0", 4'd0, 5'b10000, 1'b1, 8'd0);
    send8(4'b0001); chk8("up1", 4'd1, 5'b11000, 1'b1, 8'd0);
    send8(4'b0011); chk8("up2", 4'd2, 5'b11000, 1'b1, 8'd0);
    send8(4'b0010); chk8("up3", 4'd3, 5'b11000, 1'b1, 8'd0);

    // Wrap 15->0 then 0->15
    do_reset();
    send8(4'b1000); chk8("wr_lock", 4'd15, 5'b10000, 1'b1, 8'd0);
    send8(4'b0000); chk8("wr_up",   4'd0,  5'b11010, 1'b1, 8'd0);
    send8(4'b1000); chk8("wr_dn",   4'd15, 5'b10110, 1'b1, 8'd0);

    // Single-bit Gray change that is not a +-1 binary step, then resync
    do_reset();
    send8(4'b0001); chk8("er_lock", 4'd1,  5'b10000, 1'b1, 8'd0);
    send8(4'b1001); chk8("er_err",  4'd14, 5'b10001, 1'b0, 8'd1);
    send8(4'b1011); chk8("er_rsy",  4'd13, 5'b10000, 1'b1, 8'd1);
    // 13 -> 14 is a +1 step from the new reference
    send8(4'b1001); chk8("er_step", 4'd14, 5'b11000, 1'b1, 8'd1);

    // Mid-stream reset with a sample present: sample discarded, counter cleared
    bus8.valid_in = 1'b1;
    bus8.gray_in  = 4'b1111;
    do_reset();
    bus8.valid_in = 1'b0;
    chk8("mr_rst", 4'd0, 5'b00000, 1'b0, 8'd0);
    idle();
    chk8("mr_idle", 4'd0, 5'b00000, 1'b0, 8'd0);
    send8(4'b0101); chk8("mr_first", 4'd6, 5'b10000, 1'b1, 8'd0);

    // Repeated sample and idle gaps
    do_reset();
    send8(4'b0110); chk8("rp0", 4'd4, 5'b10000, 1'b1, 8'd0);
    send8(4'b0110); chk8("rp1", 4'd4, 5'b10000, 1'b1, 8'd0);
    send8(4'b0110); chk8("rp2", 4'd4, 5'b10000, 1'b1, 8'd0);
    idle();         chk8("gap0", 4'd4, 5'b00000, 1'b1, 8'd0);
    idle();         chk8("gap1", 4'd4, 5'b00000, 1'b1, 8'd0);
    send8(4'b0111); chk8("gap_up", 4'd5, 5'b11000, 1'b1, 8'd0);

    // Counter saturation on the narrow instance
    do_reset();
    send2(4'b0000);
    chk("sat_lock", 32'(bus2.locked), 32'd1);
    for (int i = 0; i < 5; i++) begin
      send2(4'b0110);
      chk("sat_err", 32'(bus2.step_err), 32'd1);
      chk("sat_cnt", 32'(bus2.err_count), (i < 3) ? 32'(i + 1) : 32'd3);
      send2(4'b0000);
      chk("sat_rsy", 32'({bus2.step_err, bus2.locked}), 32'b01);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
